// File: rtl/loss_test_sequencer_if.sv
// Per-run result handshake between the loss test sequencer and the reporting path.
// The master holds the result fields stable while res_valid is high.
interface loss_test_sequencer_if;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_count;
    logic [31:0] res_ok;
    logic [31:0] res_ng;
    logic [31:0] res_lost;
    logic        res_timeout;

    modport master (
        output res_valid,
        output res_count,
        output res_ok,
        output res_ng,
        output res_lost,
        output res_timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_count,
        input  res_ok,
        input  res_ng,
        input  res_lost,
        input  res_timeout,
        output res_ready
    );
endinterface

// File: rtl/loss_test_sequencer.sv
// Run controller for the receive-side loss detector: resets it, waits for done or
// timeout, latches its counters per run and keeps saturating totals over a sequence.
module loss_test_sequencer #(
    parameter int unsigned NUM_RUNS       = 4,
    parameter int unsigned RST_CYCLES     = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd125_000_000,
    parameter logic [2:0]  DONE_STATE     = 3'd3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [2:0]             det_state,
    input  logic [31:0]            det_count,
    input  logic [31:0]            det_ok,
    input  logic [31:0]            det_ng,
    input  logic [31:0]            det_lost,
    output logic                   det_rst,
    output logic                   busy,
    output logic [7:0]             run_idx,
    loss_test_sequencer_if.master  res,
    output logic [31:0]            tot_ok,
    output logic [31:0]            tot_ng,
    output logic [31:0]            tot_lost,
    output logic                   seq_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_LATCH,
        S_REPORT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [7:0]  LAST_RUN = 8'(NUM_RUNS - 1);
    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = TIMEOUT_CYCLES - 32'd1;

    state_t      state;
    logic [31:0] cnt;
    logic        timed_out;
    logic        done_seen;

    // cnt is zero only in the first MEASURE cycle, where a stale DONE is masked
    assign done_seen = (det_state == DONE_STATE) && (cnt != '0);

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            timed_out       <= 1'b0;
            det_rst         <= 1'b1;
            busy            <= 1'b0;
            run_idx         <= '0;
            seq_done        <= 1'b0;
            tot_ok          <= '0;
            tot_ng          <= '0;
            tot_lost        <= '0;
            res.res_valid   <= 1'b0;
            res.res_count   <= '0;
            res.res_ok      <= '0;
            res.res_ng      <= '0;
            res.res_lost    <= '0;
            res.res_timeout <= 1'b0;
        end else if (abort) begin
            state         <= S_IDLE;
            det_rst       <= 1'b1;
            busy          <= 1'b0;
            seq_done      <= 1'b0;
            res.res_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_CLEAR;
                        cnt      <= '0;
                        run_idx  <= '0;
                        tot_ok   <= '0;
                        tot_ng   <= '0;
                        tot_lost <= '0;
                        det_rst  <= 1'b1;
                        busy     <= 1'b1;
                        seq_done <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (cnt == RST_LAST) begin
                        state   <= S_MEASURE;
                        cnt     <= '0;
                        det_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_MEASURE: begin
                    if (done_seen) begin
                        state     <= S_LATCH;
                        timed_out <= 1'b0;
                    end else if (cnt == TO_LAST) begin
                        state     <= S_LATCH;
                        timed_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_LATCH: begin
                    state           <= S_REPORT;
                    res.res_valid   <= 1'b1;
                    res.res_count   <= det_count;
                    res.res_ok      <= det_ok;
                    res.res_ng      <= det_ng;
                    res.res_lost    <= det_lost;
                    res.res_timeout <= timed_out;
                    tot_ok          <= sat_add(tot_ok, det_ok);
                    tot_ng          <= sat_add(tot_ng, det_ng);
                    tot_lost        <= sat_add(tot_lost, det_lost);
                end
                S_REPORT: begin
                    if (res.res_ready) begin
                        state         <= S_NEXT;
                        res.res_valid <= 1'b0;
                    end
                end
                S_NEXT: begin
                    if (run_idx == LAST_RUN) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        seq_done <= 1'b1;
                    end else begin
                        state   <= S_CLEAR;
                        cnt     <= '0;
                        run_idx <= run_idx + 8'd1;
                        det_rst <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    det_rst <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loss_test_sequencer.sv
// Randomized bench for loss_test_sequencer: detector stimulus from the bench,
// expected per-run results and saturating totals from a behavioural model.
module tb_loss_test_sequencer;

    localparam int          NR = 2;
    localparam int          RC = 4;
    localparam logic [31:0] TO = 32'd50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  det_state = '0;
    logic [31:0] det_count = '0;
    logic [31:0] det_ok = '0;
    logic [31:0] det_ng = '0;
    logic [31:0] det_lost = '0;
    logic        det_rst;
    logic        busy;
    logic [7:0]  run_idx;
    logic [31:0] tot_ok;
    logic [31:0] tot_ng;
    logic [31:0] tot_lost;
    logic        seq_done;

    loss_test_sequencer_if res_if();

    loss_test_sequencer #(
        .NUM_RUNS(NR),
        .RST_CYCLES(RC),
        .TIMEOUT_CYCLES(TO),
        .DONE_STATE(3'd3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .det_state(det_state),
        .det_count(det_count),
        .det_ok(det_ok),
        .det_ng(det_ng),
        .det_lost(det_lost),
        .det_rst(det_rst),
        .busy(busy),
        .run_idx(run_idx),
        .res(res_if.master),
        .tot_ok(tot_ok),
        .tot_ng(tot_ng),
        .tot_lost(tot_lost),
        .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] e_ok = '0;
    logic [31:0] e_ng = '0;
    logic [31:0] e_lost = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    endfunction

    task automatic chk_reset(input string tag);
        check({tag, "_det_rst"}, 32'(det_rst), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_run_idx"}, 32'(run_idx), 32'd0);
        check({tag, "_valid"}, 32'(res_if.res_valid), 32'd0);
        check({tag, "_res_count"}, res_if.res_count, 32'd0);
        check({tag, "_res_ok"}, res_if.res_ok, 32'd0);
        check({tag, "_res_ng"}, res_if.res_ng, 32'd0);
        check({tag, "_res_lost"}, res_if.res_lost, 32'd0);
        check({tag, "_res_to"}, 32'(res_if.res_timeout), 32'd0);
        check({tag, "_tot_ok"}, tot_ok, 32'd0);
        check({tag, "_tot_ng"}, tot_ng, 32'd0);
        check({tag, "_tot_lost"}, tot_lost, 32'd0);
        check({tag, "_seq_done"}, 32'(seq_done), 32'd0);
    endtask

    // Leaves the bench at the first CLEAR step of run 0.
    task automatic start_seq();
        start = 1'b1;
        step();
        start = 1'b0;
        e_ok = '0;
        e_ng = '0;
        e_lost = '0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_tot_ok", tot_ok, e_ok);
        check("start_tot_ng", tot_ng, e_ng);
        check("start_tot_lost", tot_lost, e_lost);
    endtask

    // Starts at the first CLEAR step of run r. k: MEASURE cycle where done
    // is first presented (<1 or >TO-1 means the run must time out).
    task automatic do_run(
        input int r, input int k, input int bp, input bit stale,
        input int abort_j, input int rst_i,
        input logic [31:0] v_ok, input logic [31:0] v_ng,
        input logic [31:0] v_lost, input logic [31:0] v_cnt
    );
        int  hi;
        int  j;
        int  lat;
        bit  to;
        det_ok = v_ok;
        det_ng = v_ng;
        det_lost = v_lost;
        det_count = v_cnt;
        det_state = stale ? 3'd3 : 3'd0;
        res_if.res_ready = (bp == 0);
        check("run_idx", 32'(run_idx), 32'(r));
        hi = 0;
        while (det_rst && hi < 100) begin
            hi++;
            step();
        end
        check("det_rst_cycles", 32'(hi), 32'(RC));
        to = !(k >= 1 && k <= int'(TO) - 1);
        lat = (to ? int'(TO) : k + 1) + 1;
        j = 0;
        while (!res_if.res_valid && j < 200) begin
            if (j == abort_j) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_det_rst", 32'(det_rst), 32'd1);
                check("abort_valid", 32'(res_if.res_valid), 32'd0);
                check("abort_seq_done", 32'(seq_done), 32'd0);
                check("abort_tot_ok", tot_ok, e_ok);
                check("abort_tot_ng", tot_ng, e_ng);
                check("abort_tot_lost", tot_lost, e_lost);
                return;
            end
            det_state = ((k >= 0 && j >= k) || (stale && j == 0)) ? 3'd3 : 3'd0;
            step();
            j++;
        end
        check("latency", 32'(j), 32'(lat));
        e_ok = sat(e_ok, v_ok);
        e_ng = sat(e_ng, v_ng);
        e_lost = sat(e_lost, v_lost);
        check("res_count", res_if.res_count, v_cnt);
        check("res_ok", res_if.res_ok, v_ok);
        check("res_ng", res_if.res_ng, v_ng);
        check("res_lost", res_if.res_lost, v_lost);
        check("res_timeout", 32'(res_if.res_timeout), 32'(to));
        check("tot_ok", tot_ok, e_ok);
        check("tot_ng", tot_ng, e_ng);
        check("tot_lost", tot_lost, e_lost);
        check("report_busy", 32'(busy), 32'd1);
        for (int i = 0; i < bp; i++) begin
            if (i == rst_i) begin
                #2 rst = 1'b0;
                #1 chk_reset("async_rst");
                e_ok = '0;
                e_ng = '0;
                e_lost = '0;
                res_if.res_ready = 1'b0;
                #2 rst = 1'b1;
                return;
            end
            det_ok = $urandom;
            det_ng = $urandom;
            det_lost = $urandom;
            det_count = $urandom;
            det_state = 3'($urandom);
            step();
            check("bp_valid", 32'(res_if.res_valid), 32'd1);
            check("bp_ok", res_if.res_ok, v_ok);
        end
        check("hold_count", res_if.res_count, v_cnt);
        check("hold_ng", res_if.res_ng, v_ng);
        check("hold_lost", res_if.res_lost, v_lost);
        res_if.res_ready = 1'b1;
        step();
        check("valid_drop", 32'(res_if.res_valid), 32'd0);
        res_if.res_ready = 1'b0;
        det_state = 3'd0;
        step();
        if (r == NR - 1) begin
            check("done_seq_done", 32'(seq_done), 32'd1);
            check("done_busy", 32'(busy), 32'd0);
            check("done_tot_ok", tot_ok, e_ok);
        end else begin
            check("next_det_rst", 32'(det_rst), 32'd1);
            check("next_busy", 32'(busy), 32'd1);
        end
    endtask

    initial begin
        res_if.res_ready = 1'b0;
        repeat (3) step();
        chk_reset("reset");
        rst = 1'b1;
        step();
        chk_reset("idle");

        start_seq();
        for (int r = 0; r < NR; r++)
            do_run(r, 20, 0, 0, -1, -1, 32'd100, 32'd2, 32'd5, $urandom);
        check("nom_tot_ok", tot_ok, 32'd200);
        check("nom_tot_lost", tot_lost, 32'd10);

        start_seq();
        do_run(0, -1, 30, 0, -1, -1, $urandom, $urandom, $urandom, $urandom);
        do_run(1, int'(TO) - 1, 0, 0, -1, -1, $urandom, $urandom, $urandom, $urandom);

        start_seq();
        do_run(0, int'($urandom_range(1, 40)), 0, 0, -1, -1, $urandom, $urandom, $urandom, $urandom);
        do_run(1, 20, 0, 0, 10, -1, $urandom, $urandom, $urandom, $urandom);

        start_seq();
        for (int r = 0; r < NR; r++)
            do_run(r, int'($urandom_range(1, 30)), 0, 0, -1, -1,
                   32'hFFFF_FFF0, $urandom_range(0, 1000), $urandom_range(0, 1000), $urandom);
        check("sat_tot_ok", tot_ok, 32'hFFFF_FFFF);

        start_seq();
        do_run(0, int'($urandom_range(1, 30)), 10, 0, -1, 3, $urandom, $urandom, $urandom, $urandom);
        step();

        for (int s = 0; s < 3; s++) begin
            start_seq();
            for (int r = 0; r < NR; r++)
                do_run(r, int'($urandom_range(1, 55)), int'($urandom_range(0, 4)), 1, -1, -1,
                       $urandom, $urandom, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
